// File: rtl/if_fetch_pkg.sv
// Shared RV32I pipeline constants for the fetch stage and its neighbours.
// NOP_IS is the bubble encoding that decode expects while vld is low.
package if_fetch_pkg;
    localparam int unsigned     XLEN             = 32;
    localparam logic [XLEN-1:0] NOP_IS           = '0;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;
    localparam int unsigned     IS_BYTES         = 4;
    localparam int unsigned     CNT_W            = 3;
endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: assembles each 32-bit instruction from four byte reads
// and presents it to decode, buffering one instruction while decode stalls.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br,
    input  logic [XLEN-1:0] br_pc,
    input  logic            mem_busy,
    input  logic [7:0]      mem_d,
    output logic            mem_re,
    output logic [XLEN-1:0] mem_a,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] is,
    output logic            vld
);

    logic [XLEN-1:0]  fpc;
    logic [XLEN-1:0]  abuf;
    logic [CNT_W-1:0] cnt;
    logic             pend;
    logic [1:0]       pidx;
    logic             full;
    logic             cap_last;
    logic             take;

    always_comb begin
        mem_re   = rst && (cnt < CNT_W'(IS_BYTES)) && !full && !mem_busy && !br;
        mem_a    = fpc + XLEN'(cnt);
        cap_last = pend && (pidx == 2'(IS_BYTES - 1));
        take     = !vld || !stall;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc  <= RESET_PC;
            cnt  <= '0;
            pend <= 1'b0;
            pidx <= '0;
            abuf <= '0;
            full <= 1'b0;
            vld  <= 1'b0;
            is   <= NOP_IS;
            pc   <= '0;
        end else if (br) begin
            fpc  <= br_pc & ~XLEN'(3);
            cnt  <= '0;
            pend <= 1'b0;
            full <= 1'b0;
            vld  <= 1'b0;
            is   <= NOP_IS;
            pc   <= '0;
        end else begin
            pend <= mem_re;
            if (mem_re) begin
                pidx <= cnt[1:0];
                cnt  <= cnt + 1'b1;
            end
            if (pend)
                abuf[8*pidx +: 8] <= mem_d;

            // The final byte is forwarded straight into is so a free output
            // slot costs no extra cycle; abuf/full only hold it across a stall.
            if (full && take) begin
                pc   <= fpc;
                is   <= abuf;
                vld  <= 1'b1;
                fpc  <= fpc + XLEN'(IS_BYTES);
                cnt  <= '0;
                full <= 1'b0;
            end else if (cap_last && take) begin
                pc   <= fpc;
                is   <= {mem_d, abuf[23:0]};
                vld  <= 1'b1;
                fpc  <= fpc + XLEN'(IS_BYTES);
                cnt  <= '0;
                full <= 1'b0;
            end else begin
                if (cap_last)
                    full <= 1'b1;
                if (vld && !stall) begin
                    vld <= 1'b0;
                    is  <= NOP_IS;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed timing scenarios plus randomized busy/stall/
// redirect traffic against a byte-level fetch model and an address-hashed memory.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] br_pc = '0;
    logic        mem_busy = 1'b0;
    logic [7:0]  mem_d = '0;
    logic        mem_re;
    logic [31:0] mem_a;
    logic [31:0] pc;
    logic [31:0] is;
    logic        vld;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [31:0] m_fa;
    int          m_iss;
    bit          m_infl;
    int          m_rcv;
    bit          m_ready;
    bit          m_vld;
    logic [31:0] m_pc;

    // last sampled DUT values
    logic        s_re;
    logic [31:0] s_a, s_pc, s_is;
    logic        s_vld;

    if_fetch #(.RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .br(br), .br_pc(br_pc),
        .mem_busy(mem_busy), .mem_d(mem_d), .mem_re(mem_re), .mem_a(mem_a),
        .pc(pc), .is(is), .vld(vld)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'd0: return 8'h13;
            32'd1: return 8'h05;
            32'd2: return 8'h10;
            32'd3: return 8'h00;
            default: begin
                h = a * 32'h9E3779B1;
                return h[31:24] ^ a[7:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
    endfunction

    // Memory returns the addressed byte one cycle later; garbage otherwise.
    always @(posedge clk)
        mem_d <= mem_re ? byte_at(mem_a) : 8'($urandom);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fa = 32'h0; m_iss = 0; m_infl = 0; m_rcv = 0; m_ready = 0; m_vld = 0; m_pc = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; mem_busy = 0; stall = 0; br = 0;
        #1;
        check("rst_vld", vld, 0);
        check("rst_is", is, 0);
        check("rst_pc", pc, 0);
        check("rst_re", mem_re, 0);
        model_reset();
    endtask

    task automatic run_cycle(input bit b, input bit s, input bit r,
                             input logic [31:0] t, input bit do_rst);
        bit          exp_re, done, tk;
        logic [31:0] exp_a, exp_is;
        @(negedge clk);
        if (do_rst) begin
            rst = 1'b0;
            #1;
            check("arst_vld", vld, 0);
            check("arst_re", mem_re, 0);
            model_reset();
        end
        rst = 1'b1;
        mem_busy = b; stall = s; br = r; br_pc = t;
        #1;
        exp_re = (m_iss < 4) && !m_ready && !b && !r;
        exp_a  = m_fa + 32'(m_iss);
        exp_is = m_vld ? word_at(m_pc) : 32'h0;
        s_re = mem_re; s_a = mem_a; s_pc = pc; s_is = is; s_vld = vld;
        check("mem_re", mem_re, exp_re);
        check("mem_a", mem_a, exp_a);
        check("vld", vld, m_vld);
        check("is", is, exp_is);
        if (m_vld) check("pc", pc, m_pc);

        if (r) begin
            m_fa = t & ~32'h3; m_iss = 0; m_infl = 0; m_rcv = 0; m_ready = 0; m_vld = 0;
        end else begin
            done = m_infl && (m_rcv == 3);
            tk   = !m_vld || !s;
            if (m_infl) m_rcv++;
            m_infl = exp_re;
            if (exp_re) m_iss++;
            if ((m_ready || done) && tk) begin
                m_vld = 1; m_pc = m_fa; m_fa = m_fa + 32'd4;
                m_iss = 0; m_rcv = 0; m_ready = 0;
            end else begin
                if (done) m_ready = 1;
                if (m_vld && !s) m_vld = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(0, 0, 0, '0, 0);
    endtask

    initial begin
        // first fetch after reset
        do_reset();
        for (int c = 0; c < 6; c++) begin
            run_cycle(0, 0, 0, '0, 0);
            if (c < 4) check("a_seq", s_a, 32'(c));
        end
        check("c5_vld", s_vld, 1);
        check("c5_pc", s_pc, 32'h0);
        check("c5_is", s_is, 32'h00100513);

        // mem_busy in cycles 1-2
        do_reset();
        run_cycle(0, 0, 0, '0, 0);
        run_cycle(1, 0, 0, '0, 0);
        run_cycle(1, 0, 0, '0, 0);
        run_cycle(0, 0, 0, '0, 0);
        check("busy_a3", s_a, 32'h1);
        idle(2);
        run_cycle(0, 0, 0, '0, 0);
        check("busy_c6_vld", s_vld, 0);
        run_cycle(0, 0, 0, '0, 0);
        check("busy_c7_vld", s_vld, 1);
        check("busy_c7_is", s_is, 32'h00100513);

        // stall held for 10 cycles from cycle 5
        do_reset();
        idle(5);
        for (int c = 5; c < 15; c++) run_cycle(0, 1, 0, '0, 0);
        check("stall_pc", s_pc, 32'h0);
        check("stall_vld", s_vld, 1);
        check("stall_re", s_re, 0);
        run_cycle(0, 0, 0, '0, 0);
        run_cycle(0, 0, 0, '0, 0);
        check("unstall_pc", s_pc, 32'h4);
        check("unstall_is", s_is, word_at(32'h4));

        // redirect with a byte pending
        do_reset();
        idle(2);
        run_cycle(0, 0, 1, 32'h103, 0);
        run_cycle(0, 0, 0, '0, 0);
        check("br_vld", s_vld, 0);
        check("br_is", s_is, 0);
        check("br_a", s_a, 32'h100);
        idle(4);
        run_cycle(0, 0, 0, '0, 0);
        check("br_tgt_pc", s_pc, 32'h100);
        check("br_tgt_is", s_is, word_at(32'h100));

        // redirect coincident with stall while valid
        do_reset();
        idle(5);
        run_cycle(0, 1, 1, 32'h200, 0);
        check("flush_pre_vld", s_vld, 1);
        run_cycle(0, 1, 0, '0, 0);
        check("flush_vld", s_vld, 0);

        // address wrap at the top of memory
        run_cycle(0, 0, 1, 32'hFFFFFFFF, 0);
        idle(5);
        run_cycle(0, 0, 0, '0, 0);
        check("wrap_pc0", s_pc, 32'hFFFFFFFC);
        check("wrap_a0", s_a, 32'h0);
        idle(4);
        run_cycle(0, 0, 0, '0, 0);
        check("wrap_pc1", s_pc, 32'h0);
        check("wrap_is1", s_is, 32'h00100513);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          b, s, r, rs;
            logic [31:0] t;
            b  = ($urandom % 4) == 0;
            s  = ($urandom % 5) < 2;
            r  = ($urandom % 25) == 0;
            rs = ($urandom % 200) == 0;
            t  = (($urandom % 4) == 0) ? (32'hFFFFFFF0 | 32'($urandom % 16)) : 32'($urandom);
            run_cycle(b, s, r, t, rs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the decode stage. Fetches each 32-bit instruction as four little-endian byte reads over the shared byte-wide synchronous memory port. It presents `pc`/`is`/`vld` to decode, with a one-instruction assembly buffer so fetch continues while decode is stalled. Handles branch redirects and memory-port contention from the MEM stage.

## Interface
- `RESET_PC`, default 32'h0: first fetch address after reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall`  in  1  decode cannot accept; hold `pc`/`is`/`vld`.
- `br`  in  1  one-cycle redirect pulse from EX.
- `br_pc`  in  32  redirect target; bits [1:0] ignored (treated as 00).
- `mem_busy`  in  1  MEM stage owns the port this cycle; no fetch read issued.
- `mem_d`  in  8  read data, valid the cycle after a read is issued.
- `mem_re`  out  1  read request (combinational).
- `mem_a`  out  32  byte address, `fpc + cnt` (combinational).
- `pc`  out  32  address of presented instruction.
- `is`  out  32  presented instruction; 32'h0 whenever `vld`=0 (decode treats it as a bubble).
- `vld`  out  1  `is` holds a real instruction.

## Operation
- State: `fpc` (fetch PC), `cnt` (0..4, next byte to issue), `pend` plus `pidx` (read issued last cycle and its byte index), `abuf` (32-bit assembly buffer), `full` (abuf complete), output regs `pc`/`is`/`vld`.
- Reset (`rst`=0): `fpc`=RESET_PC, `cnt`=0, `pend`=0, `full`=0, `vld`=0, `is`=0, `pc`=0. `mem_re` is forced to 0 while `rst`=0.
- Issue: `mem_re`=1 iff `cnt`<4, `full`=0, `mem_busy`=0 and `br`=0. On issue, `pend`<=1, `pidx`<=`cnt`, `cnt`<=`cnt`+1.
- `mem_busy`=1: no issue and `cnt` holds. A byte pending from the previous cycle is still captured.
- Capture: if `pend`, `abuf[8*pidx+7:8*pidx]`<=`mem_d`. Capture with `pidx`=3 sets `full`.
- Hand-off: when `full` and (`vld`=0 or `stall`=0), at that edge `pc`<=`fpc`, `is`<=`abuf`, `vld`<=1, `fpc`<=`fpc`+4, `cnt`<=0, `full`<=0.
- Consume without refill: when `vld`=1, `stall`=0 and no hand-off occurs, then `vld`<=0 and `is`<=0.
- `vld`=1 and `stall`=1: outputs hold. Fetch completes into `abuf`, then stops issuing until `stall` drops.
- Redirect (`br`=1) overrides stall, hand-off and capture. At the edge: `fpc`<=`{br_pc[31:2],2'b00}`, `cnt`<=0, `pend`<=0 (the byte returning next cycle is discarded), `full`<=0, `vld`<=0, `is`<=0, `pc`<=0. No read is issued in the `br` cycle.
- `fpc` wraps modulo 2^32 (32'hFFFFFFFC+4 = 0). Byte addresses `fpc+cnt` also wrap.

## Timing
- Read latency is 1: byte issued in cycle n is captured at the end of cycle n+1.
- No busy/stall: reads in cycles 0–3, last capture at end of cycle 4, `vld`=1 in cycle 5. Next reads start in cycle 5. Steady state: one `vld` pulse every 5 cycles.
- Each cycle of `mem_busy` during `cnt`<4 adds one cycle of latency.
- Redirect in cycle n: `vld`=0 in n+1, first read of target in n+1, target instruction valid in n+6.
- Reset released mid-fetch: restarts from RESET_PC. A partial `abuf` is never presented.

## Structure
- Shared pipeline package holds: XLEN=32, `NOP_IS`=32'h0 (bubble encoding shared with decode), default RESET_PC, and the instruction byte count (4).
- Single module; no sub-module. The byte assembler is small enough to stay inline.

## Test plan
- Reset release, RESET_PC=0, memory bytes 0..3 = 13 05 10 00 -> `mem_a` 0,1,2,3 in cycles 0–3; cycle 5 `vld`=1, `pc`=0, `is`=32'h00100513.
- `mem_busy`=1 for cycles 1–2 of the first fetch -> `mem_a` sequence 0,–,–,1,2,3; `vld` rises in cycle 7 with the same `is`.
- `stall`=1 held from cycle 5 for 10 cycles -> `pc`=0/`is` held; second instruction (addr 4) fills `abuf` and reads stop. `stall`=0 -> next cycle `pc`=4. No byte is lost or re-read.
- `br`=1, `br_pc`=32'h103 while `cnt`=2 with a byte pending -> next cycle `vld`=0, `is`=0, `mem_a`=32'h100. Stale byte not written; `is` later reads from addresses 0x100–0x103.
- `br` coincident with `stall`=1 and `vld`=1 -> `vld`=0 next cycle (flush wins).
- RESET_PC=32'hFFFFFFFC, run two fetches -> second fetch `pc`=0, `mem_a` 0..3.
